fir_tdf_param: RTL and testbench

//  Parametrised transposed-direct-form FIR filter: NTAPS signed taps, run-time

---
 rtl/fir_tdf_param.sv | 95 +++++++++
 tb/tb_fir_tdf_param.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fir_tdf_param.sv
// Transposed-direct-form FIR with a writable coefficient bank, valid-qualified input
// and a saturating output register.
module fir_tdf_param #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int NTAPS = 4,
  parameter int OW    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [DW-1:0]       Xn,
  input  logic                       clear,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]       coef_data,
  output logic                       out_valid,
  output logic signed [OW-1:0]       Yn,
  output logic                       sat_flag
);

  localparam int AW   = $clog2(NTAPS);
  localparam int ACCW = DW + CW + AW;
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [CW-1:0]   coef_q [NTAPS];
  logic signed [CW-1:0]   coef_d [NTAPS];
  // dly_q[i] holds partial sum D[i+1]; D[0] does not exist in transposed form
  logic signed [ACCW-1:0] dly_q  [NTAPS-1];
  logic signed [ACCW-1:0] dly_d  [NTAPS-1];
  logic signed [ACCW-1:0] prod   [NTAPS];
  logic signed [ACCW-1:0] acc;
  logic signed [OW-1:0]   yn_q, yn_d;
  logic                   out_valid_q, out_valid_d;
  logic                   sat_q, sat_d;

  always_comb begin
    for (int k = 0; k < NTAPS; k++) begin
      prod[k] = ACCW'(coef_q[k]) * ACCW'(Xn);
    end
    acc = dly_q[0] + prod[0];

    coef_d = coef_q;
    for (int k = 0; k < NTAPS; k++) begin
      if (coef_we && coef_addr == AW'(k)) coef_d[k] = coef_data;
    end

    dly_d       = dly_q;
    yn_d        = yn_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;

    if (clear) begin
      for (int k = 0; k < NTAPS-1; k++) dly_d[k] = '0;
    end else if (in_valid) begin
      for (int k = 0; k < NTAPS-2; k++) begin
        dly_d[k] = dly_q[k+1] + prod[k+1];
      end
      dly_d[NTAPS-2] = prod[NTAPS-1];
      out_valid_d    = 1'b1;
      if (acc > SAT_MAX) begin
        yn_d  = SAT_MAX[OW-1:0];
        sat_d = 1'b1;
      end else if (acc < SAT_MIN) begin
        yn_d  = SAT_MIN[OW-1:0];
        sat_d = 1'b1;
      end else begin
        yn_d  = acc[OW-1:0];
        sat_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) coef_q[k] <= CW'(k + 1);
      for (int k = 0; k < NTAPS-1; k++) dly_q[k] <= '0;
      yn_q        <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      coef_q      <= coef_d;
      dly_q       <= dly_d;
      yn_q        <= yn_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end

  assign Yn        = yn_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_tdf_param.sv
// Directed bench for fir_tdf_param: a default 4-tap/16-bit instance and a
// 3-tap/8-bit instance for narrow-output clipping and out-of-range coefficient writes.
module tb_fir_tdf_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              a_in_valid = 1'b0, a_clear = 1'b0, a_coef_we = 1'b0;
  logic signed [7:0] a_xn = '0, a_coef_data = '0;
  logic [1:0]        a_coef_addr = '0;
  logic              a_out_valid, a_sat;
  logic signed [15:0] a_yn;

  logic              b_in_valid = 1'b0, b_clear = 1'b0, b_coef_we = 1'b0;
  logic signed [7:0] b_xn = '0, b_coef_data = '0;
  logic [1:0]        b_coef_addr = '0;
  logic              b_out_valid, b_sat;
  logic signed [7:0] b_yn;

  int errors = 0;
  int checks = 0;

  fir_tdf_param #(.DW(8), .CW(8), .NTAPS(4), .OW(16)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .Xn(a_xn), .clear(a_clear),
    .coef_we(a_coef_we), .coef_addr(a_coef_addr), .coef_data(a_coef_data),
    .out_valid(a_out_valid), .Yn(a_yn), .sat_flag(a_sat));

  fir_tdf_param #(.DW(8), .CW(8), .NTAPS(3), .OW(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .Xn(b_xn), .clear(b_clear),
    .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_data(b_coef_data),
    .out_valid(b_out_valid), .Yn(b_yn), .sat_flag(b_sat));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic signed [7:0] x, input logic clr,
                        input logic we, input logic [1:0] addr, input logic signed [7:0] data);
    a_in_valid = v; a_xn = x; a_clear = clr;
    a_coef_we = we; a_coef_addr = addr; a_coef_data = data;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_clear = 1'b0; a_coef_we = 1'b0;
  endtask

  task automatic step_b(input logic v, input logic signed [7:0] x, input logic clr,
                        input logic we, input logic [1:0] addr, input logic signed [7:0] data);
    b_in_valid = v; b_xn = x; b_clear = clr;
    b_coef_we = we; b_coef_addr = addr; b_coef_data = data;
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_clear = 1'b0; b_coef_we = 1'b0;
  endtask

  task automatic out_a(input string tag, input int y, input logic ov, input logic s);
    chk({tag, ".yn"}, 32'(a_yn), y);
    chk({tag, ".ov"}, 32'(a_out_valid), 32'(ov));
    chk({tag, ".sat"}, 32'(a_sat), 32'(s));
  endtask

  task automatic out_b(input string tag, input int y, input logic ov, input logic s);
    chk({tag, ".yn"}, 32'(b_yn), y);
    chk({tag, ".ov"}, 32'(b_out_valid), 32'(ov));
    chk({tag, ".sat"}, 32'(b_sat), 32'(s));
  endtask

  initial begin
    int imp_x [5];
    int imp_y [5];
    int stp_y [5];
    imp_x = '{1, 0, 0, 0, 0};
    imp_y = '{1, 2, 3, 4, 0};
    stp_y = '{10, 30, 60, 100, 100};

    #2;
    out_a("reset_a", 0, 1'b0, 1'b0);
    out_b("reset_b", 0, 1'b0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;

    // impulse, default coefficients
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 8'(imp_x[i]), 1'b0, 1'b0, 2'd0, 8'sd0);
      out_a($sformatf("impulse%0d", i), imp_y[i], 1'b1, 1'b0);
    end

    // impulse with three idle cycles after each sample
    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 8'(imp_x[i]), 1'b0, 1'b0, 2'd0, 8'sd0);
      out_a($sformatf("gap%0d", i), imp_y[i], 1'b1, 1'b0);
      for (int j = 0; j < 3; j++) begin
        step_a(1'b0, 8'sd77, 1'b0, 1'b0, 2'd0, 8'sd0);
        out_a($sformatf("gap%0d_idle%0d", i, j), imp_y[i], 1'b0, 1'b0);
      end
    end

    for (int i = 0; i < 5; i++) begin
      step_a(1'b1, 8'sd10, 1'b0, 1'b0, 2'd0, 8'sd0);
      out_a($sformatf("step%0d", i), stp_y[i], 1'b1, 1'b0);
    end

    step_a(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    out_a("clear_hold", 100, 1'b0, 1'b0);

    // same-cycle coefficient write uses the old h0
    step_a(1'b1, 8'sd2, 1'b0, 1'b1, 2'd0, -8'sd5);
    out_a("coefw_old", 2, 1'b1, 1'b0);
    step_a(1'b1, 8'sd2, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("coefw_new", -6, 1'b1, 1'b0);

    // all taps 127: positive and negative clipping at 16 bits
    step_a(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    for (int k = 0; k < 4; k++) step_a(1'b0, 8'sd0, 1'b0, 1'b1, 2'(k), 8'sd127);
    step_a(1'b1, 8'sd127, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satp0", 16129, 1'b1, 1'b0);
    step_a(1'b1, 8'sd127, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satp1", 32258, 1'b1, 1'b0);
    step_a(1'b1, 8'sd127, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satp2", 32767, 1'b1, 1'b1);
    step_a(1'b1, 8'sd127, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satp3", 32767, 1'b1, 1'b1);
    step_a(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    step_a(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satn0", -16256, 1'b1, 1'b0);
    step_a(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satn1", -32512, 1'b1, 1'b0);
    step_a(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("satn2", -32768, 1'b1, 1'b1);
    step_a(1'b0, 8'sd0, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("sat_hold", -32768, 1'b0, 1'b1);

    // async reset between edges, then confirm default coefficients returned
    step_a(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0);
    #2 reset = 1'b1;
    #1;
    out_a("async_rst", 0, 1'b0, 1'b0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    out_a("post_rst", 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step_a(1'b1, 8'(imp_x[i]), 1'b0, 1'b0, 2'd0, 8'sd0);
      out_a($sformatf("rst_coef%0d", i), imp_y[i], 1'b1, 1'b0);
    end

    // clear mid-impulse discards the same-cycle sample and the partial sums
    step_a(1'b1, 8'sd1, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("clr_imp", 1, 1'b1, 1'b0);
    step_a(1'b1, 8'sd50, 1'b1, 1'b0, 2'd0, 8'sd0);
    out_a("clr_cyc", 1, 1'b0, 1'b0);
    step_a(1'b1, 8'sd0, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_a("clr_after", 0, 1'b1, 1'b0);

    // 3-tap, 8-bit output instance
    step_b(1'b1, 8'sd100, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_b("b_step0", 100, 1'b1, 1'b0);
    step_b(1'b1, 8'sd100, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_b("b_step1", 127, 1'b1, 1'b1);
    step_b(1'b1, 8'sd100, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_b("b_step2", 127, 1'b1, 1'b1);
    step_b(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    step_b(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_b("b_min_edge", -128, 1'b1, 1'b0);
    step_b(1'b1, -8'sd128, 1'b0, 1'b0, 2'd0, 8'sd0);
    out_b("b_neg_clip", -128, 1'b1, 1'b1);
    step_b(1'b0, 8'sd0, 1'b1, 1'b0, 2'd0, 8'sd0);
    step_b(1'b0, 8'sd0, 1'b0, 1'b1, 2'd3, 8'sd99);
    for (int i = 0; i < 4; i++) begin
      step_b(1'b1, 8'(imp_x[i]), 1'b0, 1'b0, 2'd0, 8'sd0);
      out_b($sformatf("b_oor%0d", i), (i < 3) ? i + 1 : 0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
